// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle CPU: FSM states, instruction
// classes, opcode/funct constants and datapath select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JREG
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_ADDI, C_XORI, C_LW, C_SW, C_BNE, C_J, C_JAL, C_JR, C_ILLEGAL
    } opclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_BRANCH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

endpackage

// File: rtl/opclass_decode.sv
// Combinational instruction classifier: opcode/funct to instruction class,
// plus the ALU operation an R-type ALU instruction needs.
module opclass_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] i_instruction,
    output opclass_t    o_class,
    output logic [2:0]  o_r_aluop
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused_bits;

    assign w_op          = i_instruction[31:26];
    assign w_fn          = i_instruction[5:0];
    assign w_unused_bits = ^i_instruction[25:6];

    always_comb begin
        o_class   = C_ILLEGAL;
        o_r_aluop = ALU_ADD;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD: begin o_class = C_RALU; o_r_aluop = ALU_ADD; end
                    FN_SUB: begin o_class = C_RALU; o_r_aluop = ALU_SUB; end
                    FN_SLT: begin o_class = C_RALU; o_r_aluop = ALU_SLT; end
                    FN_JR:  o_class = C_JR;
                    default: o_class = C_ILLEGAL;
                endcase
            end
            OP_LW:   o_class = C_LW;
            OP_SW:   o_class = C_SW;
            OP_J:    o_class = C_J;
            OP_JAL:  o_class = C_JAL;
            OP_BNE:  o_class = C_BNE;
            OP_ADDI: o_class = C_ADDI;
            OP_XORI: o_class = C_XORI;
            default: o_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select and strobe, and counts retired instructions.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             iord,
    output logic             regdst,
    output logic             memtoreg,
    output logic             jal,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic             ext_zero,
    output logic [2:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t     r_state;
    state_t     w_next;
    opclass_t   w_class;
    logic [2:0] w_r_aluop;
    logic       w_retire;
    logic [CNT_W-1:0] r_retired;

    opclass_decode u_decode (
        .i_instruction (instruction),
        .o_class       (w_class),
        .o_r_aluop     (w_r_aluop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

    // DECODE only returns to FETCH on an illegal encoding, which does not retire.
    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_DECODE);

    always_comb begin
        w_next   = r_state;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        jal      = 1'b0;
        alusrc_a = 1'b0;
        alusrc_b = ALUB_REG;
        ext_zero = 1'b0;
        aluop    = ALU_ADD;
        pcsrc    = PC_ALU;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_re   = 1'b1;
                alusrc_b = ALUB_FOUR;
                ir_we    = mem_ready;
                pc_we    = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                alusrc_b = ALUB_BRANCH;
                case (w_class)
                    C_RALU:         w_next = S_EXEC_R;
                    C_ADDI, C_XORI: w_next = S_EXEC_I;
                    C_LW, C_SW:     w_next = S_MEM_ADDR;
                    C_BNE:          w_next = S_BRANCH;
                    C_J, C_JAL:     w_next = S_JUMP;
                    C_JR:           w_next = S_JREG;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alusrc_a = 1'b1;
                aluop    = w_r_aluop;
                w_next   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alusrc_a = 1'b1;
                alusrc_b = ALUB_IMM;
                if (w_class == C_XORI) begin
                    aluop    = ALU_XOR;
                    ext_zero = 1'b1;
                end
                w_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we = 1'b1;
                regdst = (w_class == C_RALU);
                w_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = ALUB_IMM;
                w_next   = (w_class == C_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord   = 1'b1;
                mem_re = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_we   = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_WR: begin
                iord   = 1'b1;
                mem_we = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_BRANCH: begin
                alusrc_a = 1'b1;
                aluop    = ALU_SUB;
                pcsrc    = PC_ALUOUT;
                pc_we    = ~zero;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc  = PC_JUMP;
                pc_we  = 1'b1;
                if (w_class == C_JAL) begin
                    jal    = 1'b1;
                    reg_we = 1'b1;
                end
                w_next = S_FETCH;
            end
            S_JREG: begin
                pcsrc  = PC_REGA;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
        // Reset wins over whatever the current state would strobe this cycle.
        if (reset) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences are
// built from the instruction semantics and checked every cycle.
module tb_multicycle_control;

    localparam int CW = 4;

    typedef struct packed {
        logic       pc_we, ir_we, reg_we, mem_re, mem_we, iord, regdst, memtoreg, jal, alusrc_a;
        logic [1:0] alusrc_b;
        logic       ext_zero;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        outs_t         outs;
        outs_t         mask;
        logic [CW-1:0] ret;
        logic          chk_ret;
    } exp_t;

    localparam int EW = $bits(exp_t);

    localparam int K_R = 0, K_ADDI = 1, K_XORI = 2, K_LW = 3, K_SW = 4, K_BNE = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

    logic clk = 1'b1;
    logic reset, zero, mem_ready;
    logic [31:0] instruction;
    logic pc_we, ir_we, reg_we, mem_re, mem_we, iord, regdst, memtoreg, jal, alusrc_a;
    logic [1:0] alusrc_b, pcsrc;
    logic ext_zero, illegal;
    logic [2:0] aluop;
    logic [CW-1:0] retired;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_ret  = 0;
    int cyc_no = 0;
    outs_t full_mask;
    outs_t en_mask;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_re(mem_re), .mem_we(mem_we), .iord(iord), .regdst(regdst),
        .memtoreg(memtoreg), .jal(jal), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
        .ext_zero(ext_zero), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal),
        .retired(retired)
    );

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        exp_t  e;
        outs_t got;
        if (exp_q.size() > 0) begin
            e   = exp_t'(exp_q.pop_front());
            got = '{pc_we, ir_we, reg_we, mem_re, mem_we, iord, regdst, memtoreg, jal,
                    alusrc_a, alusrc_b, ext_zero, aluop, pcsrc, illegal};
            checks++;
            if ((got & e.mask) !== (e.outs & e.mask)) begin
                errors++;
                $display("FAIL outs cycle %0d: got %h expected %h (mask %h)",
                         cyc_no, got, e.outs, e.mask);
            end
            if (e.chk_ret) begin
                checks++;
                if (retired !== e.ret) begin
                    errors++;
                    $display("FAIL retired cycle %0d: got %0d expected %0d", cyc_no, retired, e.ret);
                end
            end
            cyc_no++;
        end
    end

    task automatic chk_lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input outs_t o, input outs_t m, input logic rdy, input logic [31:0] ins,
                       input logic z, input logic rst, input logic cr, inout int ncyc);
        exp_t e;
        reset       = rst;
        mem_ready   = rdy;
        instruction = ins;
        zero        = z;
        e.outs    = o;
        e.mask    = m;
        e.ret     = CW'(n_ret);
        e.chk_ret = cr;
        exp_q.push_back(EW'(e));
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction; mem_ready toggles in states where it must be ignored.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int fwait,
                             input int mwait, input logic abort, output int ncyc);
        int         k;
        logic [2:0] rop;
        outs_t      o;
        logic [5:0] op;
        logic [5:0] fn;
        op   = ins[31:26];
        fn   = ins[5:0];
        rop  = 3'b000;
        ncyc = 0;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: begin k = K_R; rop = 3'b000; end
                    6'b100010: begin k = K_R; rop = 3'b001; end
                    6'b101010: begin k = K_R; rop = 3'b011; end
                    6'b001000: k = K_JR;
                    default:   k = K_ILL;
                endcase
            end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000010: k = K_J;
            6'b000011: k = K_JAL;
            6'b000101: k = K_BNE;
            6'b001000: k = K_ADDI;
            6'b001110: k = K_XORI;
            default:   k = K_ILL;
        endcase

        for (int i = 0; i < fwait; i++) begin
            o = '0; o.mem_re = 1; o.alusrc_b = 2'b01;
            cyc(o, full_mask, 1'b0, 32'hFFFF_FFFF, z, 1'b0, 1'b1, ncyc);
        end
        o = '0; o.mem_re = 1; o.alusrc_b = 2'b01; o.ir_we = 1; o.pc_we = 1;
        cyc(o, full_mask, 1'b1, 32'hFFFF_FFFF, z, 1'b0, 1'b1, ncyc);

        o = '0; o.alusrc_b = 2'b11; o.illegal = (k == K_ILL);
        cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);

        case (k)
            K_R, K_ADDI, K_XORI: begin
                o = '0; o.alusrc_a = 1;
                if (k == K_R) o.aluop = rop;
                else begin
                    o.alusrc_b = 2'b10;
                    if (k == K_XORI) begin o.aluop = 3'b010; o.ext_zero = 1; end
                end
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
                o = '0; o.reg_we = 1; o.regdst = (k == K_R);
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
            end
            K_LW, K_SW: begin
                o = '0; o.alusrc_a = 1; o.alusrc_b = 2'b10;
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
                o = '0; o.iord = 1;
                if (k == K_LW) o.mem_re = 1; else o.mem_we = 1;
                for (int i = 0; i < mwait; i++)
                    cyc(o, full_mask, 1'b0, ins, z, 1'b0, 1'b1, ncyc);
                if (abort) begin
                    cyc('0, en_mask, 1'b0, ins, z, 1'b1, 1'b1, ncyc);
                    n_ret = 0;
                end else begin
                    cyc(o, full_mask, 1'b1, ins, z, 1'b0, 1'b1, ncyc);
                    if (k == K_LW) begin
                        o = '0; o.reg_we = 1; o.memtoreg = 1;
                        cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
                    end
                end
            end
            K_BNE: begin
                o = '0; o.alusrc_a = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.pc_we = ~z;
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
            end
            K_J, K_JAL: begin
                o = '0; o.pcsrc = 2'b10; o.pc_we = 1;
                if (k == K_JAL) begin o.jal = 1; o.reg_we = 1; end
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
            end
            K_JR: begin
                o = '0; o.pcsrc = 2'b11; o.pc_we = 1;
                cyc(o, full_mask, ncyc[0], ins, z, 1'b0, 1'b1, ncyc);
            end
            default: ;
        endcase
        if (k != K_ILL && !abort) n_ret++;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        logic [31:0] loop_tab[6];
        full_mask = '1;
        en_mask   = '0;
        en_mask.pc_we = 1; en_mask.ir_we = 1; en_mask.reg_we = 1;
        en_mask.mem_re = 1; en_mask.mem_we = 1; en_mask.illegal = 1;
        loop_tab = '{32'h012A4020, 32'h8D280004, 32'h1509FFFF,
                     32'h392800FF, 32'h08000010, 32'hAD280004};

        n = 0;
        cyc('0, en_mask, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, n);
        cyc('0, en_mask, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, n);
        chk_lit("retired_after_reset", int'(retired), 0);

        run_instr(32'h012A4020, 1'b0, 0, 0, 1'b0, n);  // add $8,$9,$10
        chk_lit("add_cycles", n, 4);
        chk_lit("add_retired", int'(retired), 1);
        run_instr(32'h8D280004, 1'b0, 0, 2, 1'b0, n);  // lw, two wait states
        chk_lit("lw_wait_cycles", n, 7);
        run_instr(32'h1509FFFF, 1'b0, 0, 0, 1'b0, n);  // bne taken
        chk_lit("bne_taken_cycles", n, 3);
        run_instr(32'h1509FFFF, 1'b1, 0, 0, 1'b0, n);  // bne not taken
        chk_lit("bne_not_taken_cycles", n, 3);
        run_instr(32'h0C000010, 1'b0, 0, 0, 1'b0, n);  // jal
        chk_lit("jal_cycles", n, 3);
        run_instr(32'h03E00008, 1'b0, 0, 0, 1'b0, n);  // jr $31
        chk_lit("jr_cycles", n, 3);
        chk_lit("retired_after_jr", int'(retired), 6);

        run_instr(32'hFC000000, 1'b0, 0, 0, 1'b0, n);  // opcode 111111
        chk_lit("illegal_cycles", n, 2);
        run_instr(32'h012A4021, 1'b0, 0, 0, 1'b0, n);  // unsupported funct
        chk_lit("illegal_retired", int'(retired), 6);

        run_instr(32'h012A4022, 1'b0, 2, 0, 1'b0, n);  // sub, fetch waits
        chk_lit("sub_fetch_wait_cycles", n, 6);
        run_instr(32'h012A402A, 1'b0, 0, 0, 1'b0, n);  // slt
        run_instr(32'h21280005, 1'b0, 0, 0, 1'b0, n);  // addi
        run_instr(32'h392800FF, 1'b0, 0, 0, 1'b0, n);  // xori
        run_instr(32'hAD280004, 1'b0, 0, 1, 1'b0, n);  // sw, one wait
        chk_lit("sw_wait_cycles", n, 5);
        run_instr(32'h08000010, 1'b0, 0, 0, 1'b0, n);  // j
        chk_lit("retired_12", int'(retired), 12);

        for (int i = 0; i < 6; i++)
            run_instr(loop_tab[i], i[0], i % 2, i % 3, 1'b0, n);
        chk_lit("retired_wrap", int'(retired), 2);

        run_instr(32'hAD280004, 1'b0, 0, 1, 1'b1, n);  // sw aborted by reset
        chk_lit("abort_retired", int'(retired), 0);
        run_instr(32'h012A4020, 1'b0, 0, 0, 1'b0, n);
        chk_lit("retired_after_abort", int'(retired), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the CPU datapath. Reads the latched instruction register and ALU zero flag, then sequences the datapath for each supported instruction through fetch, decode, execute, memory and writeback states. It drives all datapath mux selects, write enables and the memory handshake, and counts retired instructions. It sits between the instruction register / ALU / register file / unified memory and replaces per-instruction combinational decode.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `instruction` in 32: instruction register contents, valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `pc_we`, `ir_we`, `reg_we`, `mem_re`, `mem_we` out 1 each: write enables and memory strobes.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `regdst` out 1: write register select. 0 = rt, 1 = rd.
- `memtoreg` out 1: write data select. 0 = ALUOut, 1 = MDR.
- `jal` out 1: forces destination $31 and write data PC.
- `alusrc_a` out 1: ALU A input. 0 = PC, 1 = reg A.
- `alusrc_b` out 2: ALU B input. 00 = reg B, 01 = 4, 10 = extended imm, 11 = sign-ext imm<<2.
- `ext_zero` out 1: zero-extend the immediate instead of sign-extending it.
- `aluop` out 3: 000 ADD, 001 SUB, 010 XOR, 011 SLT.
- `pcsrc` out 2: PC input. 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A.
- `illegal` out 1: one-cycle pulse on an unsupported encoding.
- `retired` out CNT_W: count of completed instructions.

## Operation
- Supported opcodes: LW 100011, SW 101011, J 000010, JAL 000011, BNE 000101, ADDI 001000, XORI 001110.
- R-type uses opcode 000000 and dispatches on funct: ADD 100000, SUB 100010, SLT 101010, JR 001000.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JREG.
- Every output not listed for a state is 0.
- **FETCH:** drives `mem_re`=1, `iord`=0, A=PC, B=4, ADD, `pcsrc`=00. `ir_we` and `pc_we` equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE:** drives A=PC, B=11, ADD, which precomputes the branch target into ALUOut. Next state by class:
  - R-ALU → EXEC_R.
  - ADDI/XORI → EXEC_I.
  - LW/SW → MEM_ADDR.
  - BNE → BRANCH.
  - J/JAL → JUMP.
  - JR → JREG.
  - Anything else → FETCH with `illegal`=1.
- **EXEC_R:** A=1, B=00, aluop from funct. Next: ALU_WB.
- **EXEC_I:** A=1, B=10, ADD for ADDI; XOR with `ext_zero`=1 for XORI. Next: ALU_WB.
- **ALU_WB:** `reg_we`=1, `memtoreg`=0, `regdst`=1 for R-type, 0 for I-type. Next: FETCH.
- **MEM_ADDR:** A=1, B=10, ADD. Next: MEM_RD for LW, MEM_WR for SW.
- **MEM_RD:** `iord`=1, `mem_re`=1. Holds until `mem_ready`, then goes to MEM_WB.
- **MEM_WB:** `reg_we`=1, `memtoreg`=1, `regdst`=0. Next: FETCH.
- **MEM_WR:** `iord`=1, `mem_we`=1. Holds until `mem_ready`, then goes to FETCH.
- **BRANCH:** A=1, B=00, SUB, `pcsrc`=01, `pc_we`=~`zero`. Next: FETCH.
- **JUMP:** `pcsrc`=10, `pc_we`=1. For JAL, also `jal`=1 and `reg_we`=1; the PC already holds PC+4. Next: FETCH.
- **JREG:** `pcsrc`=11, `pc_we`=1. Next: FETCH.
- `retired` increments by 1 on every transition into FETCH, except from DECODE on an illegal encoding. It wraps modulo 2^CNT_W.

## Timing
- **Reset:** while `reset`=1 all enables and strobes are 0 and `illegal`=0. State loads FETCH and `retired` loads 0 at the edge.
- **Mid-instruction reset:** reset asserted during any state aborts the instruction with no write in the reset cycle. No `retired` increment.
- **Output timing:** outputs are Moore-decoded from state. The only input-qualified exceptions are `ir_we`/`pc_we` in FETCH (gated by `mem_ready`) and `pc_we` in BRANCH (gated by `zero`).
- **Minimum latency** with `mem_ready` held 1, counted FETCH to next FETCH:
  - J, JAL, JR, BNE: 3 cycles.
  - R-type, ADDI, XORI, SW: 4 cycles.
  - LW: 5 cycles.
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Strobes stay asserted for the whole wait.
- **Ignored inputs:** `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR. `instruction` is sampled only in DECODE and later states; changes while in FETCH have no effect.

## Structure
- **Shared package `cpu_ctrl_pkg`:** holds
  - the state enum;
  - opcode and funct constants;
  - aluop encodings;
  - the `alusrc_b` and `pcsrc` codes.

  The datapath imports the same package.
- **Sub-module `opclass_decode`:** combinational; maps `instruction` to an instruction-class enum plus the R-type aluop. The FSM (next-state, output decode) and the retire counter stay in the top module.

## Test plan
- **ADD:** instruction 0x012A4020 (add $8,$9,$10), `mem_ready`=1 → states FETCH, DECODE, EXEC_R (aluop 000), ALU_WB (`reg_we`=1, `regdst`=1) → back to FETCH. `retired` increments 0→1.
- **LW with wait:** instruction 0x8D280004, `mem_ready` low 2 cycles in MEM_RD → `mem_re`=1 and `iord`=1 held 3 cycles. MEM_WB shows `memtoreg`=1. Total 7 cycles.
- **BNE:** instruction 0x1509FFFF, once with `zero`=0 and once with `zero`=1 → BRANCH `pc_we`=1 with `pcsrc`=01, then `pc_we`=0. Both take 3 cycles.
- **JAL:** instruction 0x0C000010 → JUMP shows `pc_we`=1, `pcsrc`=10, `jal`=1, `reg_we`=1. JR 0x03E00008 → JREG shows `pcsrc`=11.
- **Illegal:** opcode 111111 → `illegal` high exactly one cycle in DECODE, return to FETCH, no write strobes, `retired` unchanged.
- **Reset mid-instruction:** reset asserted in MEM_WR with `mem_ready`=0 → `mem_we`=0 in that cycle. Next state FETCH, `retired`=0.
